// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART path.
// Both directions use the same parameter set and range checks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic bit uart_cfg_ok(
    input int cd,
    input int db,
    input int sb,
    input int pb
  );
    return (cd >= 4) && (cd % 2 == 0) &&
           (db >= 5) && (db <= 9) &&
           (sb == 1 || sb == 2) &&
           (pb == 0 || pb == 1);
  endfunction

  function automatic int uart_frame_bits(
    input int db,
    input int pb,
    input int sb
  );
    return 1 + db + pb + sb;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// ResetVal sets both flops so the output starts at a known level.
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= ResetVal;
      q    <= ResetVal;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of start/data/parity/stop,
// word presented on a valid/ready handshake with error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClockDivider = 8,
  parameter int DataBits     = 8,
  parameter int StopBits     = 1,
  parameter int ParityBits   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_bit,
  output logic [DataBits-1:0] data_out,
  output logic                data_out_valid,
  input  logic                data_out_ready,
  output logic                parity_error,
  output logic                frame_error,
  output logic                overrun_error
);

  if (!uart_cfg_ok(ClockDivider, DataBits,
                   StopBits, ParityBits)) begin : g_bad_cfg
    $error("uart_rx: parameter out of range");
  end

  localparam int CW = $clog2(ClockDivider);
  localparam int IW = $clog2(DataBits + 1);

  localparam logic [CW-1:0] BitLast  = CW'(ClockDivider - 1);
  localparam logic [CW-1:0] HalfLast = CW'(ClockDivider / 2 - 1);
  localparam logic [IW-1:0] DataLast = IW'(DataBits - 1);
  localparam logic [IW-1:0] StopLast = IW'(StopBits - 1);

  rx_state_e           state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [DataBits-1:0] shift;
  logic                rx_par;
  logic                fe_pend;
  logic                rx_s;

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (in_bit),
    .q  (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      shift          <= '0;
      rx_par         <= 1'b0;
      fe_pend        <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      parity_error   <= 1'b0;
      frame_error    <= 1'b0;
      overrun_error  <= 1'b0;
    end else begin
      if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
        parity_error   <= 1'b0;
        frame_error    <= 1'b0;
        overrun_error  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          cnt     <= '0;
          idx     <= '0;
          fe_pend <= 1'b0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HalfLast) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BitLast) begin
            cnt   <= '0;
            shift <= {shift[DataBits-2:0], rx_s};
            if (idx == DataLast) begin
              idx   <= '0;
              state <= (ParityBits == 1) ? PARITY : STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == BitLast) begin
            cnt    <= '0;
            rx_par <= rx_s;
            state  <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BitLast) begin
            cnt <= '0;
            if (!rx_s) fe_pend <= 1'b1;
            if (idx == StopLast) begin
              // last stop sample completes the word; back to IDLE now
              idx            <= '0;
              state          <= IDLE;
              data_out       <= shift;
              data_out_valid <= 1'b1;
              parity_error   <= (ParityBits == 1) &&
                                (rx_par != ^shift);
              frame_error    <= fe_pend || !rx_s;
              overrun_error  <= data_out_valid && !data_out_ready;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default and even-parity instances,
// expected words queued at send time and popped on valid.
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       oe;
  } exp_t;

  localparam int CD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit, in_bit_p;
  logic       ready, ready_p;
  logic [7:0] dout, dout_p;
  logic       dv, dv_p;
  logic       pe, pe_p, fe, fe_p, oe, oe_p;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic valid_pre;

  uart_rx dut (
    .clk           (clk),
    .rst           (rst),
    .in_bit        (in_bit),
    .data_out      (dout),
    .data_out_valid(dv),
    .data_out_ready(ready),
    .parity_error  (pe),
    .frame_error   (fe),
    .overrun_error (oe)
  );

  uart_rx #(
    .ParityBits(1)
  ) dut_p (
    .clk           (clk),
    .rst           (rst),
    .in_bit        (in_bit_p),
    .data_out      (dout_p),
    .data_out_valid(dv_p),
    .data_out_ready(ready_p),
    .parity_error  (pe_p),
    .frame_error   (fe_p),
    .overrun_error (oe_p)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap(input bit p, output logic v, output exp_t o);
    if (p) begin
      v = dv_p;
      o = {dout_p, pe_p, fe_p, oe_p};
    end else begin
      v = dv;
      o = {dout, pe, fe, oe};
    end
  endtask

  // one frame driven from negedges; cycle k feeds posedge E_k
  task automatic send(input bit p, input logic [7:0] d,
                      input logic par, input logic stop,
                      input int rdy_k, input int rst_k);
    logic bits[11];
    int   n;
    n = uart_frame_bits(8, p ? 1 : 0, 1);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[7-i];
    if (p) bits[9] = par;
    bits[n-1] = stop;
    for (int k = 0; k < n * CD; k++) begin
      @(negedge clk);
      if (k == n * CD - 2) valid_pre = p ? dv_p : dv;
      if (k % CD == 0) begin
        if (p) in_bit_p = bits[k/CD];
        else   in_bit   = bits[k/CD];
      end
      if (k == rdy_k) begin
        if (p) ready_p = 1'b1;
        else   ready   = 1'b1;
      end else if (k == rdy_k + 1) begin
        ready   = 1'b0;
        ready_p = 1'b0;
      end
      if (k == rst_k) rst = 1'b1;
      if (k == rst_k + 2) begin
        rst      = 1'b0;
        in_bit   = 1'b1;
        in_bit_p = 1'b1;
        return;
      end
    end
  endtask

  task automatic check_word(input bit p, input string tag);
    logic v;
    exp_t o, e;
    for (int i = 0; i < 200; i++) begin
      snap(p, v, o);
      if (v) break;
      @(negedge clk);
    end
    snap(p, v, o);
    chk({tag, "_valid"}, 32'(v), 32'd1);
    chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_data"}, 32'(o.data), 32'(e.data));
    chk({tag, "_pe"}, 32'(o.pe), 32'(e.pe));
    chk({tag, "_fe"}, 32'(o.fe), 32'(e.fe));
    chk({tag, "_oe"}, 32'(o.oe), 32'(e.oe));
  endtask

  task automatic accept(input bit p, input string tag);
    logic v;
    exp_t o;
    @(negedge clk);
    if (p) ready_p = 1'b1;
    else   ready   = 1'b1;
    @(negedge clk);
    ready   = 1'b0;
    ready_p = 1'b0;
    snap(p, v, o);
    chk({tag, "_acc_valid"}, 32'(v), 32'd0);
    chk({tag, "_acc_flags"}, 32'({o.pe, o.fe, o.oe}), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    exp_t hold;
    logic v;
    exp_t o;
    rst      = 1'b1;
    in_bit   = 1'b1;
    in_bit_p = 1'b1;
    ready    = 1'b0;
    ready_p  = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_valid", 32'(dv), 32'd0);
    chk("rst_data", 32'(dout), 32'd0);
    chk("rst_flags", 32'({pe, fe, oe}), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    idle(4);

    // 1: basic frame, latency, hold while not ready
    sb.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
    send(0, 8'hA5, 1'b0, 1'b1, -10, -10);
    chk("t1_valid_before_78", 32'(valid_pre), 32'd0);
    chk("t1_valid_at_78", 32'(dv), 32'd1);
    check_word(0, "t1");
    hold = {dout, pe, fe, oe};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_hold_valid", 32'(dv), 32'd1);
      chk("t1_hold_word", 32'({dout, pe, fe, oe}), 32'(hold));
    end
    accept(0, "t1");

    // 2: start-bit glitch
    idle(4);
    in_bit = 1'b0;
    idle(3);
    in_bit = 1'b1;
    idle(2);
    chk("t2_state_start", 32'(dut.state), 32'(START));
    idle(2);
    chk("t2_state_idle", 32'(dut.state), 32'(IDLE));
    idle(100);
    chk("t2_no_valid", 32'(dv), 32'd0);

    // 3: even parity, wrong then right
    sb.push_back('{8'h3C, 1'b1, 1'b0, 1'b0});
    send(1, 8'h3C, 1'b1, 1'b1, -10, -10);
    chk("t3_valid_at_86", 32'(dv_p), 32'd1);
    check_word(1, "t3_bad");
    accept(1, "t3_bad");
    idle(4);
    sb.push_back('{8'h3C, 1'b0, 1'b0, 1'b0});
    send(1, 8'h3C, 1'b0, 1'b1, -10, -10);
    check_word(1, "t3_good");
    accept(1, "t3_good");

    // 4: framing error then clean frame
    idle(4);
    sb.push_back('{8'h81, 1'b0, 1'b1, 1'b0});
    send(0, 8'h81, 1'b0, 1'b0, -10, -10);
    in_bit = 1'b1;
    check_word(0, "t4_bad");
    accept(0, "t4_bad");
    idle(20);
    chk("t4_no_spurious", 32'(dv), 32'd0);
    sb.push_back('{8'h7E, 1'b0, 1'b0, 1'b0});
    send(0, 8'h7E, 1'b0, 1'b1, -10, -10);
    check_word(0, "t4_good");
    accept(0, "t4_good");

    // 5: back-to-back, overrun then ready on completion
    idle(4);
    sb.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
    send(0, 8'h11, 1'b0, 1'b1, -10, -10);
    check_word(0, "t5_first");
    sb.push_back('{8'h22, 1'b0, 1'b0, 1'b1});
    send(0, 8'h22, 1'b0, 1'b1, -10, -10);
    check_word(0, "t5_ovr");
    accept(0, "t5_ovr");
    idle(4);
    sb.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
    send(0, 8'h11, 1'b0, 1'b1, -10, -10);
    check_word(0, "t5_first2");
    sb.push_back('{8'h22, 1'b0, 1'b0, 1'b0});
    send(0, 8'h22, 1'b0, 1'b1, 78, -10);
    check_word(0, "t5_xfer");

    // 6: reset mid-frame, then a clean frame
    send(0, 8'h55, 1'b0, 1'b1, -10, 30);
    idle(1);
    snap(0, v, o);
    chk("t6_rst_valid", 32'(v), 32'd0);
    chk("t6_rst_word", 32'(o), 32'd0);
    chk("t6_rst_state", 32'(dut.state), 32'(IDLE));
    idle(100);
    chk("t6_no_valid", 32'(dv), 32'd0);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);
    sb.push_back('{8'hF0, 1'b0, 1'b0, 1'b0});
    send(0, 8'hF0, 1'b0, 1'b1, -10, -10);
    check_word(0, "t6_f0");
    accept(0, "t6_f0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
